// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller for one NOC output port; holds a grant for a whole wormhole packet.
// Optional watchdog release is compiled in with RR_GRANT_TIMEOUT_EN.
module rr_grant_ctrl #(
   parameter int unsigned NUM_PORTS      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [NUM_PORTS-1:0] priority_order_i,
   input  logic                 xfer_i,
   input  logic                 tail_i,
   output logic [NUM_PORTS-1:0] grant_o,
   output logic                 grant_valid_o,
   output logic                 change_order_o,
   output logic                 timeout_o
);

   if (NUM_PORTS != 4) begin : gen_bad_ports
      $error("rr_grant_ctrl supports exactly 4 ports");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gen_bad_timeout
      $error("rr_grant_ctrl TIMEOUT_CYCLES must be 1..255");
   end

   typedef enum logic [1:0] {StIdle, StGrant, StSettle} state_e;

   state_e               state_q, state_d;
   logic [NUM_PORTS-1:0] grant_q, grant_d;
   logic                 change_order_q, change_order_d;
   logic [1:0]           prio_idx;
   logic [1:0]           idx;
   logic                 found;
   logic [NUM_PORTS-1:0] pick;
   logic                 tail_rel;
   logic                 timeout_rel;

   assign tail_rel = xfer_i & tail_i;

   // Lowest set bit wins, so malformed or empty vectors still resolve to a single index.
   always_comb begin
      prio_idx = 2'd0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (priority_order_i[i]) prio_idx = 2'(i);
      end
   end

   // Descending search from the priority index, matching the register's rotation direction.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = 2'd0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = prio_idx - 2'(k);
         if (!found && req_i[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
   end

`ifdef RR_GRANT_TIMEOUT_EN
   localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

   logic [7:0] cnt_q, cnt_d;
   logic       timeout_q, timeout_d;

   assign timeout_rel = (cnt_q == TimeoutLimit);

   always_comb begin
      cnt_d     = 8'd0;
      timeout_d = timeout_q;
      if (state_q == StGrant) begin
         if (!tail_rel && timeout_rel) begin
            timeout_d = 1'b1;
         end else if (!xfer_i) begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;
`else
   assign timeout_rel = 1'b0;
   assign timeout_o   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (|req_i) state_d = StGrant;
         StGrant:  if (tail_rel || timeout_rel) state_d = StSettle;
         StSettle: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      grant_d        = grant_q;
      change_order_d = 1'b0;
      case (state_q)
         StIdle: grant_d = pick;
         StGrant: begin
            if (tail_rel || timeout_rel) begin
               grant_d        = '0;
               change_order_d = 1'b1;
            end
         end
         StSettle: grant_d = '0;
         default:  grant_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         grant_q        <= '0;
         change_order_q <= 1'b0;
      end else begin
         grant_q        <= grant_d;
         change_order_q <= change_order_d;
      end
   end

   assign grant_o        = grant_q;
   assign grant_valid_o  = |grant_q;
   assign change_order_o = change_order_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed self-checking bench for rr_grant_ctrl; the stall test follows RR_GRANT_TIMEOUT_EN.
module tb_rr_grant_ctrl;

   logic       clk;
   logic       reset;
   logic [3:0] req_i;
   logic [3:0] priority_order_i;
   logic       xfer_i;
   logic       tail_i;
   logic [3:0] grant_o;
   logic       grant_valid_o;
   logic       change_order_o;
   logic       timeout_o;

   int checks;
   int failures;

   rr_grant_ctrl #(
      .NUM_PORTS      (4),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .req_i            (req_i),
      .priority_order_i (priority_order_i),
      .xfer_i           (xfer_i),
      .tail_i           (tail_i),
      .grant_o          (grant_o),
      .grant_valid_o    (grant_valid_o),
      .change_order_o   (change_order_o),
      .timeout_o        (timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One rising edge; outputs are then read 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Tail transfer, then one settle cycle; leaves the DUT in IDLE with inputs quiet.
   task automatic release_pkt();
      xfer_i = 1'b1;
      tail_i = 1'b1;
      step();
      xfer_i = 1'b0;
      tail_i = 1'b0;
      req_i  = 4'b0000;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_i = 4'b1111;
      priority_order_i = 4'b0001;
      xfer_i = 1'b0;
      tail_i = 1'b0;
      step();
      step();
      checks++;
      if (grant_o !== 4'b0000 || grant_valid_o !== 1'b0 || change_order_o !== 1'b0 ||
          timeout_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_values: got grant=%b gv=%b co=%b to=%b, want 0000 0 0 0",
                  grant_o, grant_valid_o, change_order_o, timeout_o);
      end
      reset = 1'b0;
      req_i = 4'b0000;
      step();
   endtask

   task automatic test_basic_rotate();
      priority_order_i = 4'b0100;
      req_i = 4'b1111;
      step();
      checks++;
      if (grant_o !== 4'b0100 || grant_valid_o !== 1'b1) begin
         failures++;
         $display("FAIL basic_grant: got grant=%b gv=%b, want 0100 1", grant_o, grant_valid_o);
      end
      xfer_i = 1'b1;
      tail_i = 1'b1;
      step();
      checks++;
      if (grant_o !== 4'b0000 || change_order_o !== 1'b1) begin
         failures++;
         $display("FAIL basic_release: got grant=%b co=%b, want 0000 1", grant_o, change_order_o);
      end
      xfer_i = 1'b0;
      tail_i = 1'b0;
      priority_order_i = 4'b0010;
      step();
      checks++;
      if (grant_o !== 4'b0000 || change_order_o !== 1'b0) begin
         failures++;
         $display("FAIL basic_settle: got grant=%b co=%b, want 0000 0", grant_o, change_order_o);
      end
      step();
      checks++;
      if (grant_o !== 4'b0010) begin
         failures++;
         $display("FAIL basic_regrant: got grant=%b, want 0010", grant_o);
      end
      release_pkt();
   endtask

   task automatic test_search_order();
      logic [3:0] prio_v [5] = '{4'b0100, 4'b0001, 4'b1000, 4'b0000, 4'b0110};
      logic [3:0] req_v  [5] = '{4'b1001, 4'b1010, 4'b0111, 4'b0110, 4'b1111};
      logic [3:0] exp_v  [5] = '{4'b0001, 4'b1000, 4'b0100, 4'b0100, 4'b0010};
      for (int i = 0; i < 5; i++) begin
         priority_order_i = prio_v[i];
         req_i = req_v[i];
         step();
         checks++;
         if (grant_o !== exp_v[i]) begin
            failures++;
            $display("FAIL search_order[%0d]: prio=%b req=%b got grant=%b, want %b",
                     i, prio_v[i], req_v[i], grant_o, exp_v[i]);
         end
         release_pkt();
      end
   endtask

   task automatic test_hold_5flit();
      logic [3:0] other_req [5] = '{4'b0111, 4'b0001, 4'b0110, 4'b0000, 4'b0101};
      priority_order_i = 4'b1000;
      req_i = 4'b1111;
      step();
      checks++;
      if (grant_o !== 4'b1000) begin
         failures++;
         $display("FAIL hold_start: got grant=%b, want 1000", grant_o);
      end
      for (int f = 1; f <= 5; f++) begin
         req_i  = other_req[f-1];
         xfer_i = 1'b1;
         tail_i = (f == 5);
         step();
         checks++;
         if (f < 5 && (grant_o !== 4'b1000 || change_order_o !== 1'b0)) begin
            failures++;
            $display("FAIL hold_flit%0d: got grant=%b co=%b, want 1000 0",
                     f, grant_o, change_order_o);
         end else if (f == 5 && (grant_o !== 4'b0000 || change_order_o !== 1'b1)) begin
            failures++;
            $display("FAIL hold_release: got grant=%b co=%b, want 0000 1",
                     grant_o, change_order_o);
         end
      end
      xfer_i = 1'b0;
      tail_i = 1'b0;
      req_i  = 4'b1111;
      step();
      checks++;
      if (change_order_o !== 1'b0 || grant_o !== 4'b0000) begin
         failures++;
         $display("FAIL hold_single_pulse: got grant=%b co=%b, want 0000 0",
                  grant_o, change_order_o);
      end
      req_i = 4'b0000;
      step();
   endtask

   task automatic test_idle_ignores_xfer();
      req_i  = 4'b0000;
      xfer_i = 1'b1;
      tail_i = 1'b1;
      step();
      step();
      checks++;
      if (grant_o !== 4'b0000 || change_order_o !== 1'b0 || grant_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL idle_ignore: got grant=%b gv=%b co=%b, want 0000 0 0",
                  grant_o, grant_valid_o, change_order_o);
      end
      xfer_i = 1'b0;
      tail_i = 1'b0;
   endtask

   task automatic test_reset_mid_packet();
      priority_order_i = 4'b0001;
      req_i = 4'b0001;
      step();
      xfer_i = 1'b1;
      tail_i = 1'b0;
      step();
      checks++;
      if (grant_o !== 4'b0001) begin
         failures++;
         $display("FAIL midrst_pre: got grant=%b, want 0001", grant_o);
      end
      reset = 1'b1;
      req_i = 4'b1111;
      step();
      checks++;
      if (grant_o !== 4'b0000 || change_order_o !== 1'b0 || grant_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL midrst_clear: got grant=%b gv=%b co=%b, want 0000 0 0",
                  grant_o, grant_valid_o, change_order_o);
      end
      reset  = 1'b0;
      xfer_i = 1'b0;
      req_i  = 4'b0010;
      step();
      checks++;
      if (grant_o !== 4'b0010) begin
         failures++;
         $display("FAIL midrst_regrant: got grant=%b, want 0010", grant_o);
      end
      release_pkt();
   endtask

   task automatic test_stall();
      priority_order_i = 4'b0001;
      req_i = 4'b0100;
      xfer_i = 1'b0;
      tail_i = 1'b0;
      step();
      checks++;
      if (grant_o !== 4'b0100) begin
         failures++;
         $display("FAIL stall_grant: got grant=%b, want 0100", grant_o);
      end
      req_i = 4'b0000;
`ifdef RR_GRANT_TIMEOUT_EN
      for (int c = 1; c <= 5; c++) begin
         step();
         checks++;
         if (c < 5 && (grant_o !== 4'b0100 || change_order_o !== 1'b0 || timeout_o !== 1'b0)) begin
            failures++;
            $display("FAIL stall_hold%0d: got grant=%b co=%b to=%b, want 0100 0 0",
                     c, grant_o, change_order_o, timeout_o);
         end else if (c == 5 &&
                      (grant_o !== 4'b0000 || change_order_o !== 1'b1 || timeout_o !== 1'b1)) begin
            failures++;
            $display("FAIL stall_timeout: got grant=%b co=%b to=%b, want 0000 1 1",
                     grant_o, change_order_o, timeout_o);
         end
      end
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (timeout_o !== 1'b1 || change_order_o !== 1'b0) begin
            failures++;
            $display("FAIL stall_sticky%0d: got to=%b co=%b, want 1 0", c, timeout_o,
                     change_order_o);
         end
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (timeout_o !== 1'b0) begin
         failures++;
         $display("FAIL stall_to_reset: got to=%b, want 0", timeout_o);
      end
`else
      for (int c = 1; c <= 100; c++) begin
         step();
         checks++;
         if (grant_o !== 4'b0100 || change_order_o !== 1'b0 || timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold%0d: got grant=%b co=%b to=%b, want 0100 0 0",
                     c, grant_o, change_order_o, timeout_o);
         end
      end
      release_pkt();
`endif
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic_rotate();
      test_search_order();
      test_hold_5flit();
      test_idle_ignores_xfer();
      test_reset_mid_packet();
      test_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
